keypad_emulator: RTL and testbench

- Synthesizable 4x4 matrix-keypad model that sits on the far end of the keypad scanner's row/column interface: it receives the scanner's active-low row selects and drives active-low column returns.
- Used for hardware-in-loop and self-test builds so the scanner, debouncer and display path can run without a physical keypad.
- A command port presses or releases one key at a time.
- Each contact transition is followed by a deterministic chatter burst, which exercises the scanner's debounce logic.

---
 rtl/keypad_emulator.sv | 131 +++++++++++++
 tb/tb_keypad_emulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad model for the far end of a row/column keypad scanner.
// One key at a time is pressed or released through a valid/ready command
// port; every contact transition is followed by a deterministic chatter
// burst so the scanner's debounce path is exercised.
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned CHATTER_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_press,
    input  logic [3:0] cmd_key,
    input  logic [3:0] r_sel,
    output logic [3:0] col,
    output logic       key_down,
    output logic       bounce_active,
    output logic       cmd_err
);

    localparam int unsigned CNT_W    = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int unsigned PH_W     = (CHATTER_DIV > 1) ? $clog2(CHATTER_DIV) : 1;
    localparam int unsigned LAST_CNT = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
    localparam int unsigned LAST_PH  = (CHATTER_DIV > 0) ? CHATTER_DIV - 1 : 0;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BOUNCE_PRESS   = 2'd1,
        HELD           = 2'd2,
        BOUNCE_RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        key;
    logic              contact;
    logic [CNT_W-1:0]  cnt;
    // Position within the current chatter half-period; toggles contact on wrap.
    logic [PH_W-1:0]   ph;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    // Command handling, chatter sequencing and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            key           <= 4'h0;
            contact       <= 1'b0;
            cnt           <= '0;
            ph            <= '0;
            cmd_ready     <= 1'b1;
            key_down      <= 1'b0;
            bounce_active <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_press) begin
                            key      <= cmd_key;
                            contact  <= 1'b1;
                            cnt      <= '0;
                            ph       <= '0;
                            key_down <= 1'b1;
                            if (BOUNCE_CYCLES > 0) begin
                                state         <= BOUNCE_PRESS;
                                cmd_ready     <= 1'b0;
                                bounce_active <= 1'b1;
                            end else begin
                                state <= HELD;
                            end
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (accept) begin
                        if (cmd_press) begin
                            cmd_err <= 1'b1;
                        end else begin
                            contact <= 1'b0;
                            cnt     <= '0;
                            ph      <= '0;
                            if (BOUNCE_CYCLES > 0) begin
                                state         <= BOUNCE_RELEASE;
                                cmd_ready     <= 1'b0;
                                bounce_active <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                key_down <= 1'b0;
                            end
                        end
                    end
                end
                BOUNCE_PRESS, BOUNCE_RELEASE: begin
                    if (cnt == CNT_W'(LAST_CNT)) begin
                        // Settle to the final contact level regardless of pattern phase.
                        state         <= (state == BOUNCE_PRESS) ? HELD : IDLE;
                        contact       <= (state == BOUNCE_PRESS);
                        key_down      <= (state == BOUNCE_PRESS);
                        cmd_ready     <= 1'b1;
                        bounce_active <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (ph == PH_W'(LAST_PH)) begin
                            ph      <= '0;
                            contact <= ~contact;
                        end else begin
                            ph <= ph + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Passive switch matrix: the held key shorts its column to its row select.
    always_comb begin
        col = 4'b1111;
        if (contact && !r_sel[key[3:2]]) begin
            col[key[1:0]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus pushes expected per-cycle
// outputs into a queue, a negedge monitor pops and compares them.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       reset;

    logic       cmd_valid, cmd_press;
    logic [3:0] cmd_key, r_sel;
    logic       cmd_ready, key_down, bounce_active, cmd_err;
    logic [3:0] col;

    logic       cmd_valid0, cmd_press0;
    logic [3:0] cmd_key0, r_sel0;
    logic       cmd_ready0, key_down0, bounce_active0, cmd_err0;
    logic [3:0] col0;

    keypad_emulator dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_press(cmd_press),
        .cmd_key(cmd_key), .r_sel(r_sel), .col(col),
        .key_down(key_down), .bounce_active(bounce_active), .cmd_err(cmd_err)
    );

    keypad_emulator #(.BOUNCE_CYCLES(0), .CHATTER_DIV(2)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_press(cmd_press0),
        .cmd_key(cmd_key0), .r_sel(r_sel0), .col(col0),
        .key_down(key_down0), .bounce_active(bounce_active0), .cmd_err(cmd_err0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         sel;       // 0 = default instance, 1 = no-chatter instance
        logic [7:0] exp;       // {col, cmd_ready, key_down, bounce_active, cmd_err}
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: compare every queued expectation against the sampled outputs.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] got;
        while (q.size() > 0) begin
            e = q.pop_front();
            got = e.sel ? {col0, cmd_ready0, key_down0, bounce_active0, cmd_err0}
                        : {col,  cmd_ready,  key_down,  bounce_active,  cmd_err};
            total++;
            if (got !== e.exp) begin
                bad++;
                $display("FAIL %s: got col=%b rdy=%b kd=%b ba=%b err=%b, want col=%b rdy=%b kd=%b ba=%b err=%b",
                         e.name, got[7:4], got[3], got[2], got[1], got[0],
                         e.exp[7:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input bit sel, input logic [3:0] c,
                              input logic rdy, input logic kd, input logic ba, input logic err);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = {c, rdy, kd, ba, err};
        q.push_back(e);
    endtask

    // Drives the cycle after an accepted transition through all 8 chatter cycles.
    task automatic run_bounce(input string nm, input logic press, input logic [3:0] on_col);
        logic on;
        for (int n = 0; n < 8; n++) begin
            tick();
            cmd_valid = 1'b0;
            on = (((n / 2) % 2) == 0) ? press : ~press;
            expect_out($sformatf("%s_n%0d", nm, n), 1'b0, on ? on_col : 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    logic [3:0] rot [4];

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_press = 1'b0; cmd_key = 4'h0; r_sel = 4'b1111;
        cmd_valid0 = 1'b0; cmd_press0 = 1'b0; cmd_key0 = 4'h0; r_sel0 = 4'b1111;

        tick();
        expect_out("reset_state", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("reset_state0", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        r_sel = 4'b1101;
        expect_out("idle_after_reset", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        // Press key 6 with chatter, row 1 selected.
        tick();
        cmd_valid = 1'b1; cmd_press = 1'b1; cmd_key = 4'h6;
        expect_out("press6_issue", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        run_bounce("press6", 1'b1, 4'b1011);
        tick();
        expect_out("held6", 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        r_sel = 4'b1110;
        expect_out("held6_other_row", 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);

        // Release key 6 (cmd_key ignored on release).
        tick();
        r_sel = 4'b1101;
        cmd_valid = 1'b1; cmd_press = 1'b0; cmd_key = 4'hA;
        expect_out("release6_issue", 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        run_bounce("release6", 1'b0, 4'b1011);
        tick();
        expect_out("idle_after_release", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal release in IDLE.
        cmd_valid = 1'b1; cmd_press = 1'b0;
        tick();
        cmd_valid = 1'b0;
        expect_out("idle_release_err", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("idle_release_err_clear", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        // Press key F, then illegal press of key 0 while held.
        r_sel = 4'b0111;
        cmd_valid = 1'b1; cmd_press = 1'b1; cmd_key = 4'hF;
        run_bounce("pressF", 1'b1, 4'b0111);
        tick();
        expect_out("heldF", 1'b0, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_press = 1'b1; cmd_key = 4'h0;
        tick();
        cmd_valid = 1'b0;
        expect_out("held_press_err", 1'b0, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("held_press_err_clear", 1'b0, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);

        // Release F, then press 9 with only row 0 selected: column stays open.
        cmd_valid = 1'b1; cmd_press = 1'b0;
        run_bounce("releaseF", 1'b0, 4'b0111);
        tick();
        r_sel = 4'b1110;
        cmd_valid = 1'b1; cmd_press = 1'b1; cmd_key = 4'h9;
        expect_out("idle_before_9", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        run_bounce("press9_row0", 1'b1, 4'b1111);

        // Rotating scanner with key 9 held.
        for (int i = 0; i < 8; i++) begin
            tick();
            r_sel = rot[i % 4];
            expect_out($sformatf("rotate_%0d", i), 1'b0,
                       (rot[i % 4] == 4'b1011) ? 4'b1101 : 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick();
        r_sel = 4'b0000;
        expect_out("all_rows_low", 1'b0, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);

        // Release 9, then reset in the middle of a press bounce.
        cmd_valid = 1'b1; cmd_press = 1'b0;
        run_bounce("release9", 1'b0, 4'b1101);
        tick();
        r_sel = 4'b1101;
        cmd_valid = 1'b1; cmd_press = 1'b1; cmd_key = 4'h6;
        expect_out("idle_before_rst_press", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            cmd_valid = 1'b0;
            expect_out($sformatf("pre_rst_n%0d", n), 1'b0,
                       (n < 2) ? 4'b1011 : 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        tick();
        #1;
        reset = 1'b1;
        expect_out("mid_bounce_reset", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_press = 1'b1; cmd_key = 4'h6;
        expect_out("after_reset_idle", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        expect_out("after_reset_press_n0", 1'b0, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b0);

        // No-chatter instance: press 3 goes straight to HELD.
        r_sel0 = 4'b1110;
        cmd_valid0 = 1'b1; cmd_press0 = 1'b1; cmd_key0 = 4'h3;
        expect_out("nb_idle", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        cmd_valid0 = 1'b0;
        expect_out("nb_held3", 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        cmd_valid0 = 1'b1; cmd_press0 = 1'b0;
        expect_out("nb_held3_steady", 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        cmd_valid0 = 1'b0;
        expect_out("nb_released", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
